// File: rtl/mem_master.sv
// Initiator for the 8-bit synchronous SRAM: turns valid/ready commands into
// pipelined single/burst reads and gapped burst writes on registered memory pins.
module mem_master #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [15:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_data,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_last,
    output logic             done,
    output logic             mem_ce,
    output logic             mem_r,
    output logic             mem_w,
    output logic             mem_oe,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, RD_DRAIN, WRITE} state_t;

    localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

    state_t         state, state_nx;
    logic [LEN_W:0] cnt, cnt_nx;     // bytes still to issue (read) or to write
    logic [LEN_W:0] rcnt, rcnt_nx;   // read bytes still to be returned
    logic [15:0]    cur_addr, cur_addr_nx;
    logic           ce_nx, r_nx, w_nx, oe_nx;
    logic [15:0]    addr_nx;
    logic [7:0]     wdata_nx, rsp_data_nx;
    logic           rsp_valid_nx, rsp_last_nx, done_nx;
    logic           accept, beat, sample;

    assign req_ready = !rst && (state == IDLE);
    assign wr_ready  = !rst && (state == WRITE) && (cnt != '0);
    assign accept    = req_valid && req_ready;
    assign beat      = wr_valid && wr_ready;
    assign sample    = mem_oe && (state == READ || state == RD_DRAIN) && (rcnt != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rcnt_nx      = rcnt;
        cur_addr_nx  = cur_addr;
        ce_nx        = 1'b0;
        r_nx         = 1'b0;
        w_nx         = 1'b0;
        oe_nx        = 1'b0;
        addr_nx      = mem_addr;
        wdata_nx     = mem_wdata;
        rsp_valid_nx = 1'b0;
        rsp_data_nx  = rsp_data;
        rsp_last_nx  = 1'b0;
        done_nx      = 1'b0;

        // Read data is captured two edges behind its address issue.
        if (sample) begin
            rsp_valid_nx = 1'b1;
            rsp_data_nx  = mem_rdata;
            rcnt_nx      = rcnt - CNT_ONE;
            if (rcnt == CNT_ONE) begin
                rsp_last_nx = 1'b1;
                done_nx     = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_write) begin
                        state_nx    = WRITE;
                        cnt_nx      = {1'b0, req_len} + CNT_ONE;
                        cur_addr_nx = req_addr;
                    end else begin
                        state_nx    = READ;
                        cnt_nx      = {1'b0, req_len};
                        rcnt_nx     = {1'b0, req_len} + CNT_ONE;
                        cur_addr_nx = req_addr + 16'd1;
                        ce_nx       = 1'b1;
                        r_nx        = 1'b1;
                        addr_nx     = req_addr;
                    end
                end
            end
            READ: begin
                ce_nx = 1'b1;
                oe_nx = 1'b1;
                if (cnt != '0) begin
                    r_nx        = 1'b1;
                    addr_nx     = cur_addr;
                    cur_addr_nx = cur_addr + 16'd1;
                    cnt_nx      = cnt - CNT_ONE;
                end else begin
                    state_nx = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                state_nx = IDLE;
            end
            WRITE: begin
                if (beat) begin
                    ce_nx       = 1'b1;
                    w_nx        = 1'b1;
                    addr_nx     = cur_addr;
                    wdata_nx    = wr_data;
                    cur_addr_nx = cur_addr + 16'd1;
                    cnt_nx      = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rcnt      <= '0;
            cur_addr  <= '0;
            mem_ce    <= 1'b0;
            mem_r     <= 1'b0;
            mem_w     <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            rcnt      <= rcnt_nx;
            cur_addr  <= cur_addr_nx;
            mem_ce    <= ce_nx;
            mem_r     <= r_nx;
            mem_w     <= w_nx;
            mem_oe    <= oe_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
            rsp_last  <= rsp_last_nx;
            done      <= done_nx;
        end
    end

    // The SRAM resolves r/w overlap in favour of r, so overlap would silently drop a write.
    assert property (@(posedge clk) disable iff (rst) !(mem_r && mem_w));

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator for the 8-bit synchronous SRAM block. Drives its ce/r/w/oe/addr/in_data pins and captures out_data.
- Turns requests on a valid/ready command port into single or burst (1..256 byte) reads and writes.
- Write data arrives on a valid/ready stream; read data leaves as a one-cycle response pulse per byte.
- Sits between the CPU/DMA side and the memory; it is the only driver of the memory pins.

Parameters:
- LEN_W, 8, width of req_len; burst length = req_len+1 (1..2^LEN_W bytes).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid & req_ready at an edge
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  16  start address
- req_len  in  LEN_W  byte count minus one
- wr_valid  in  1  write-data stream valid
- wr_ready  out  1  write-data stream ready
- wr_data  in  8  write byte
- rsp_valid  out  1  read byte valid, one-cycle pulse, no backpressure
- rsp_data  out  8  read byte
- rsp_last  out  1  with rsp_valid, marks final byte of burst
- done  out  1  one-cycle pulse when a burst completes
- mem_ce, mem_r, mem_w, mem_oe  out  1 each  memory controls, all registered
- mem_addr  out  16  memory address, registered
- mem_wdata  out  8  memory in_data, registered
- mem_rdata  in  8  memory out_data

Behaviour:
- Reset: all outputs are 0, including req_ready, wr_ready, and all mem_* signals. State is IDLE. Reset mid-burst abandons the burst with no done pulse and no further rsp_valid. Memory controls are 0 from the first cycle after the reset edge.
- mem_r and mem_w are never both 1. The memory gives r priority, so any overlap is a bug; assert this.
- States: IDLE, READ, RD_DRAIN, WRITE.
- IDLE: req_ready=1 and all memory controls are 0.
  - On accept: latch addr and count = req_len+1.
  - Go to READ or WRITE according to req_write.
- READ issue, edge A (accept): registers take mem_ce=1, mem_r=1, mem_addr=req_addr.
- READ pipelining:
  - Each subsequent edge advances mem_addr by 1 (16-bit wrap, FFFF -> 0000) while bytes remain to issue.
  - mem_oe=1 from the cycle after the first issue.
  - mem_rdata is sampled every edge where mem_oe=1 and a byte is outstanding.
  - Throughput is 1 byte/cycle.
- READ latency: rsp_valid for byte k is high in the cycle following edge A+2+k.
- READ drain: after the last address issues, go to RD_DRAIN for one cycle (mem_r=0, mem_ce=1, mem_oe=1) to sample the final byte. rsp_last and done are high with the final rsp_valid. Then go to IDLE.
- WRITE handshake:
  - wr_ready=1 in WRITE while bytes remain.
  - On a beat (wr_valid & wr_ready): registers take mem_ce=1, mem_w=1, mem_addr=cur_addr, mem_wdata=wr_data. cur_addr increments with 16-bit wrap.
- WRITE stall: a cycle with no beat drives mem_ce=0, mem_w=0 on the next cycle. Bursts may be arbitrarily gapped.
- WRITE completion:
  - On the edge of the last beat: go to IDLE and pulse done in the following cycle.
  - The final write is still presented to memory in that first IDLE cycle.
  - A request accepted at the end of that cycle issues afterwards, so ordering is preserved.
- Inputs ignored outside their state:
  - req_* is ignored outside IDLE.
  - wr_valid is ignored outside WRITE; no beat is consumed.
- req_len=0 gives a 1-byte burst.
- Max-length burst: count is LEN_W+1 bits wide, so 256 bytes are handled.

Test Plan:
- Single write then read: write addr 0x0010, len 0, data 0xA5 → exactly one cycle with mem_w=1, addr 0x0010, wdata 0xA5, then done. Read of 0x0010 → rsp_valid 2 cycles after accept, rsp_data=0xA5, rsp_last=1, done=1.
- Burst of 4: write 0x11,0x22,0x33,0x44 to 0x0100 with wr_valid gaps of 0,2,0,1 cycles → mem_w only on beat cycles, at addrs 0x100..0x103. Read burst len 3 → 4 consecutive rsp_valid cycles with 0x11..0x44, rsp_last only on 0x44.
- Address wrap: read burst at 0xFFFE, len 2 → mem_addr sequence 0xFFFE, 0xFFFF, 0x0000.
- Back-to-back: read request presented the cycle after a write done → memory sees the final write before the read's mem_r. Returned data equals the written byte.
- Reset mid-read: assert rst at the cycle of the 2nd rsp_valid of an 8-byte burst → all mem_* and rsp_valid are 0 from the next cycle, no done, and req_ready returns to 1 after rst falls.
- Protocol checker over all tests: mem_r & mem_w never both 1, and mem_oe only with mem_ce.
